rtcl_hs_tx_arbiter: RTL and testbench

//  Packet-atomic arbiter in front of the HS TX width converter. Merges the image stream (video) and
//  a low-rate control/status packet stream (ctrl) into one stream and inserts a minimum idle gap

---
 rtl/rtcl_hs_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_rtcl_hs_tx_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtcl_hs_tx_arbiter.sv
// Packet-atomic arbiter merging the video and control streams ahead of the HS TX width converter.
// Video has priority, control is guaranteed a slot after MAX_STREAK video packets, and idle gaps separate packets.
module rtcl_hs_tx_arbiter #(
    parameter int DATA_BITS  = 40,
    parameter int GAP_CYCLES = 4,
    parameter int MAX_STREAK = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_vid_first,
    input  logic                 s_vid_last,
    input  logic [DATA_BITS-1:0] s_vid_data,
    input  logic                 s_vid_valid,
    output logic                 s_vid_ready,
    input  logic                 s_ctl_first,
    input  logic                 s_ctl_last,
    input  logic [DATA_BITS-1:0] s_ctl_data,
    input  logic                 s_ctl_valid,
    output logic                 s_ctl_ready,
    output logic                 m_first,
    output logic                 m_last,
    output logic                 m_src,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy
);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [GW-1:0] GAP_INIT   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {ST_IDLE, ST_VID, ST_CTL, ST_GAP} state_t;

    state_t                state_q, state_d, end_state;
    logic [SW-1:0]         streak_q, streak_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_first_q, m_first_d;
    logic                  m_last_q, m_last_d;
    logic                  m_src_q, m_src_d;
    logic [DATA_BITS-1:0]  m_data_q, m_data_d;
    logic                  out_en, vid_acc, ctl_acc;

    function automatic logic [SW-1:0] streak_sat_inc(input logic [SW-1:0] s);
        return (s >= STREAK_MAX) ? STREAK_MAX : s + SW'(1);
    endfunction

    assign out_en      = !m_valid_q || m_ready;
    assign s_vid_ready = (state_q == ST_VID) && out_en;
    assign s_ctl_ready = (state_q == ST_CTL) && out_en;
    assign vid_acc     = s_vid_valid && s_vid_ready;
    assign ctl_acc     = s_ctl_valid && s_ctl_ready;
    assign end_state   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    assign m_valid = m_valid_q;
    assign m_first = m_first_q;
    assign m_last  = m_last_q;
    assign m_src   = m_src_q;
    assign m_data  = m_data_q;
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        gap_cnt_d = gap_cnt_q;
        m_valid_d = m_valid_q;
        m_first_d = m_first_q;
        m_last_d  = m_last_q;
        m_src_d   = m_src_q;
        m_data_d  = m_data_q;

        // Output register: load a granted beat, or empty once the held beat has been taken.
        if (out_en) begin
            m_valid_d = vid_acc || ctl_acc;
            if (vid_acc) begin
                m_first_d = s_vid_first;
                m_last_d  = s_vid_last;
                m_src_d   = 1'b0;
                m_data_d  = s_vid_data;
            end else if (ctl_acc) begin
                m_first_d = s_ctl_first;
                m_last_d  = s_ctl_last;
                m_src_d   = 1'b1;
                m_data_d  = s_ctl_data;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (s_vid_valid || s_ctl_valid) begin
                    state_d = (s_ctl_valid && (!s_vid_valid || streak_q >= STREAK_MAX)) ? ST_CTL : ST_VID;
                end
            end
            ST_VID: begin
                if (vid_acc && s_vid_last) begin
                    streak_d  = streak_sat_inc(streak_q);
                    state_d   = end_state;
                    gap_cnt_d = GAP_INIT;
                end
            end
            ST_CTL: begin
                if (ctl_acc && s_ctl_last) begin
                    streak_d  = '0;
                    state_d   = end_state;
                    gap_cnt_d = GAP_INIT;
                end
            end
            ST_GAP: begin
                // Gap runs from the cycle after tlast is registered, independent of downstream accept.
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            streak_q  <= '0;
            gap_cnt_q <= '0;
            m_valid_q <= 1'b0;
            m_first_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_src_q   <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            gap_cnt_q <= gap_cnt_d;
            m_valid_q <= m_valid_d;
            m_first_q <= m_first_d;
            m_last_q  <= m_last_d;
            m_src_q   <= m_src_d;
            m_data_q  <= m_data_d;
        end
    end
endmodule

// File: tb/tb_rtcl_hs_tx_arbiter.sv
// Directed bench for rtcl_hs_tx_arbiter: per-source scoreboard queues, packet order log and idle-gap measurement.
module tb_rtcl_hs_tx_arbiter;
    localparam int DW     = 40;
    localparam int GAP    = 4;
    localparam int STREAK = 8;
    localparam int LIMIT  = 500;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          s_vid_first = 0, s_vid_last = 0, s_vid_valid = 0, s_vid_ready;
    logic [DW-1:0] s_vid_data = '0;
    logic          s_ctl_first = 0, s_ctl_last = 0, s_ctl_valid = 0, s_ctl_ready;
    logic [DW-1:0] s_ctl_data = '0;
    logic          m_first, m_last, m_src, m_valid, busy;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b1;

    logic          g0_vid_first = 0, g0_vid_last = 0, g0_vid_valid = 0, g0_vid_ready;
    logic [DW-1:0] g0_vid_data = '0;
    logic          g0_ctl_ready, g0_m_first, g0_m_last, g0_m_src, g0_m_valid, g0_busy;
    logic [DW-1:0] g0_m_data;

    rtcl_hs_tx_arbiter #(.DATA_BITS(DW), .GAP_CYCLES(GAP), .MAX_STREAK(STREAK)) u_dut (
        .clk(clk), .reset(reset),
        .s_vid_first(s_vid_first), .s_vid_last(s_vid_last), .s_vid_data(s_vid_data),
        .s_vid_valid(s_vid_valid), .s_vid_ready(s_vid_ready),
        .s_ctl_first(s_ctl_first), .s_ctl_last(s_ctl_last), .s_ctl_data(s_ctl_data),
        .s_ctl_valid(s_ctl_valid), .s_ctl_ready(s_ctl_ready),
        .m_first(m_first), .m_last(m_last), .m_src(m_src), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
    );

    rtcl_hs_tx_arbiter #(.DATA_BITS(DW), .GAP_CYCLES(0), .MAX_STREAK(STREAK)) u_gap0 (
        .clk(clk), .reset(reset),
        .s_vid_first(g0_vid_first), .s_vid_last(g0_vid_last), .s_vid_data(g0_vid_data),
        .s_vid_valid(g0_vid_valid), .s_vid_ready(g0_vid_ready),
        .s_ctl_first(1'b0), .s_ctl_last(1'b0), .s_ctl_data('0),
        .s_ctl_valid(1'b0), .s_ctl_ready(g0_ctl_ready),
        .m_first(g0_m_first), .m_last(g0_m_last), .m_src(g0_m_src), .m_data(g0_m_data),
        .m_valid(g0_m_valid), .m_ready(1'b1), .busy(g0_busy)
    );

    int tests = 0;
    int fails = 0;
    logic [DW+1:0] exp_vid[$];
    logic [DW+1:0] exp_ctl[$];
    logic          pkt_order[$];
    int            pkts_seen = 0;
    int            last_bubble = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pop, packet atomicity, stall stability and idle-gap length.
    logic          in_pkt = 0, cur_src = 0, counting = 0, stall_prev = 0;
    int            idle_cnt = 0;
    logic [DW+2:0] held = '0;
    always @(negedge clk) begin
        logic [DW+1:0] beat;
        if (stall_prev) begin
            check("hold_valid", m_valid, 1'b1);
            check("hold_beat", {m_first, m_last, m_src, m_data}, held);
        end
        if (counting && m_valid) begin
            last_bubble = idle_cnt;
            counting = 0;
        end else if (counting) begin
            idle_cnt++;
        end
        if (m_valid && m_ready) begin
            beat = {m_first, m_last, m_data};
            if (!m_src) begin
                check("vid_queue_has_beat", exp_vid.size() != 0, 1'b1);
                if (exp_vid.size() != 0) check("vid_beat", beat, exp_vid.pop_front());
            end else begin
                check("ctl_queue_has_beat", exp_ctl.size() != 0, 1'b1);
                if (exp_ctl.size() != 0) check("ctl_beat", beat, exp_ctl.pop_front());
            end
            if (in_pkt) check("pkt_atomic_src", m_src, cur_src);
            if (m_last) begin
                in_pkt = 0;
                pkt_order.push_back(m_src);
                pkts_seen++;
                counting = 1;
                idle_cnt = 0;
            end else begin
                in_pkt = 1;
                cur_src = m_src;
            end
        end
        stall_prev = m_valid && !m_ready && !reset;
        held = {m_first, m_last, m_src, m_data};
        if (reset) begin
            in_pkt = 0;
            counting = 0;
            stall_prev = 0;
        end
    end

    task automatic send_vid(input int nbeats, input logic [DW-1:0] base);
        for (int b = 0; b < nbeats; b++) begin
            int n;
            s_vid_valid = 1'b1;
            s_vid_first = (b == 0);
            s_vid_last  = (b == nbeats - 1);
            s_vid_data  = base + DW'(b);
            exp_vid.push_back({s_vid_first, s_vid_last, s_vid_data});
            n = 0;
            do begin @(negedge clk); n++; end while (!s_vid_ready && n < LIMIT);
            check("vid_accept_ready", s_vid_ready, 1'b1);
            @(posedge clk); #1;
        end
        s_vid_valid = 1'b0; s_vid_first = 1'b0; s_vid_last = 1'b0;
    endtask

    task automatic send_ctl(input int nbeats, input logic [DW-1:0] base);
        for (int b = 0; b < nbeats; b++) begin
            int n;
            s_ctl_valid = 1'b1;
            s_ctl_first = (b == 0);
            s_ctl_last  = (b == nbeats - 1);
            s_ctl_data  = base + DW'(b);
            exp_ctl.push_back({s_ctl_first, s_ctl_last, s_ctl_data});
            n = 0;
            do begin @(negedge clk); n++; end while (!s_ctl_ready && n < LIMIT);
            check("ctl_accept_ready", s_ctl_ready, 1'b1);
            @(posedge clk); #1;
        end
        s_ctl_valid = 1'b0; s_ctl_first = 1'b0; s_ctl_last = 1'b0;
    endtask

    task automatic send_g0(input int nbeats, input logic [DW-1:0] base);
        for (int b = 0; b < nbeats; b++) begin
            int n;
            g0_vid_valid = 1'b1;
            g0_vid_first = (b == 0);
            g0_vid_last  = (b == nbeats - 1);
            g0_vid_data  = base + DW'(b);
            n = 0;
            do begin @(negedge clk); n++; end while (!g0_vid_ready && n < LIMIT);
            check("g0_accept_ready", g0_vid_ready, 1'b1);
            @(posedge clk); #1;
        end
        g0_vid_valid = 1'b0; g0_vid_first = 1'b0; g0_vid_last = 1'b0;
    endtask

    task automatic wait_pkts(input int n);
        int c;
        c = 0;
        while (pkts_seen < n && c < 3000) begin @(posedge clk); c++; end
        check("pkt_count_reached", pkts_seen >= n, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_vid.delete(); exp_ctl.delete(); pkt_order.delete();
        pkts_seen = 0; last_bubble = -1;
    endtask

    initial begin
        logic [DW-1:0] g0_exp_data [5];
        logic          g0_exp_vld  [5];
        logic          g0_exp_last [5];
        bit            rdy_done;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_first", m_first, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_src", m_src, 1'b0);
        check("rst_m_data", m_data, '0);
        check("rst_vid_ready", s_vid_ready, 1'b0);
        check("rst_ctl_ready", s_ctl_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1;

        // 1: single 3-beat video packet, then the output stays quiet through the gap
        send_vid(3, 40'd1);
        wait_pkts(1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_gap_m_valid", m_valid, 1'b0);
            check("t1_gap_busy", busy, (k < 3));
        end
        check("t1_vid_drained", exp_vid.size(), 0);

        // 2: simultaneous valid, streak 0 -> video first, ctrl after gap plus idle
        @(posedge clk); #1;
        do_reset();
        fork
            send_vid(2, 40'h200);
            send_ctl(2, 40'h280);
        join
        wait_pkts(2);
        check("t2_first_src", pkt_order[0], 1'b0);
        check("t2_second_src", pkt_order[1], 1'b1);
        check("t2_bubble", last_bubble, GAP + 1);

        // 3: video always valid -> exactly STREAK video packets before each pending ctrl packet
        do_reset();
        fork
            for (int p = 0; p < 18; p++) send_vid(1, 40'h300 + DW'(p));
            for (int p = 0; p < 2; p++) send_ctl(1, 40'h380 + DW'(p));
        join
        wait_pkts(20);
        for (int i = 0; i < 20; i++) check("t3_order", pkt_order[i], (i == 8) || (i == 17));
        check("t3_bubble", last_bubble, GAP + 1);

        // 4: random backpressure, mixed packet lengths
        do_reset();
        rdy_done = 0;
        fork
            begin
                fork
                    for (int p = 0; p < 6; p++) send_vid($urandom_range(1, 4), 40'h1000 + DW'(p * 16));
                    for (int p = 0; p < 4; p++) send_ctl($urandom_range(1, 3), 40'h2000 + DW'(p * 16));
                join
                rdy_done = 1;
            end
            while (!rdy_done) begin
                @(posedge clk); #1;
                m_ready = 1'($urandom_range(0, 1));
            end
        join
        m_ready = 1'b1;
        wait_pkts(10);
        check("t4_vid_drained", exp_vid.size(), 0);
        check("t4_ctl_drained", exp_ctl.size(), 0);

        // 5: reset on the 2nd beat of a 4-beat video packet
        do_reset();
        begin
            int n;
            s_vid_valid = 1'b1; s_vid_first = 1'b1; s_vid_last = 1'b0; s_vid_data = 40'hA1;
            exp_vid.push_back({1'b1, 1'b0, 40'hA1});
            n = 0;
            do begin @(negedge clk); n++; end while (!s_vid_ready && n < LIMIT);
            check("t5_beat1_ready", s_vid_ready, 1'b1);
            @(posedge clk); #1;
            s_vid_first = 1'b0; s_vid_data = 40'hA2; reset = 1'b1;
            @(posedge clk); #1;
            check("t5_m_valid", m_valid, 1'b0);
            check("t5_vid_ready", s_vid_ready, 1'b0);
            check("t5_ctl_ready", s_ctl_ready, 1'b0);
            check("t5_busy", busy, 1'b0);
            check("t5_m_data", m_data, '0);
            check("t5_m_first_last_src", {m_first, m_last, m_src}, 3'b000);
            reset = 1'b0; s_vid_valid = 1'b0;
            @(negedge clk);
            check("t5_beat1_consumed", exp_vid.size(), 0);
            @(posedge clk); #1;
            pkts_seen = 0;
            send_vid(2, 40'hB0);
            wait_pkts(1);
            check("t5_resync_drained", exp_vid.size(), 0);
        end

        // 6: GAP_CYCLES=0, back-to-back 2-beat packets -> one idle bubble only
        g0_exp_vld  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        g0_exp_data = '{40'h61, 40'h62, 40'h0, 40'h63, 40'h64};
        g0_exp_last = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        fork
            begin
                send_g0(2, 40'h61);
                send_g0(2, 40'h63);
            end
            begin
                int n;
                n = 0;
                do begin @(negedge clk); n++; end while (!g0_m_valid && n < 100);
                check("t6_start", g0_m_valid, 1'b1);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    check("t6_valid", g0_m_valid, g0_exp_vld[k]);
                    if (g0_exp_vld[k]) begin
                        check("t6_data", g0_m_data, g0_exp_data[k]);
                        check("t6_last", g0_m_last, g0_exp_last[k]);
                    end
                end
            end
        join

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
